// File: rtl/sms32_38_inv_iter.sv
// Inverse SMS32 S-box: out_y = in_x^5 in GF(2^6) mod x^6+x^4+x^2+x+1, computed in a GF((2^3)^2) tower.
// Optional macro SMS_INV_SELFCHECK_EN adds a forward power-38 recheck that drives chk_err.

module sms32_38_inv_iter_gf_mul (
  input  logic [5:0] a,
  input  logic [5:0] b,
  output logic [5:0] p
);
  // GF(8) = GF(2)[z]/(z^3+z+1)
  function automatic logic [2:0] gf8_mul(input logic [2:0] x, input logic [2:0] y);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      if (y[i]) r = r ^ ({2'b00, x} << i);
    end
    return {r[2] ^ r[4], r[1] ^ r[3] ^ r[4], r[0] ^ r[3]};
  endfunction

  // Extension y^2 = y + 1: (h1 y + l1)(h2 y + l2)
  logic [2:0] hh;
  assign hh = gf8_mul(a[5:3], b[5:3]);
  assign p  = {hh ^ gf8_mul(a[5:3], b[2:0]) ^ gf8_mul(a[2:0], b[5:3]),
               hh ^ gf8_mul(a[2:0], b[2:0])};
endmodule

module sms32_38_inv_iter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_x,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_y
`ifdef SMS_INV_SELFCHECK_EN
  ,
  output logic       chk_err
`endif
);
  // state | meaning
  // IDLE  | waiting for an operand, in_ready=1
  // SQ    | t = w^4 via two linear squarings
  // MUL   | result = t * w on the shared multiplier
  // SC1   | (self-check) r^32 * r^4
  // SC2   | (self-check) * r^2, compare with stored in_x
  // OUT   | out_valid=1 until out_ready
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQ   = 3'd1,
    S_MUL  = 3'd2,
`ifdef SMS_INV_SELFCHECK_EN
    S_SC1  = 3'd4,
    S_SC2  = 3'd5,
`endif
    S_OUT  = 3'd3
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] w_q, w_d, t_q, t_d, out_y_q, out_y_d;
  logic [5:0] mul_a, mul_b, mul_p;

  function automatic logic [2:0] gf8_sq(input logic [2:0] a);
    return {a[1] ^ a[2], a[2], a[0]};
  endfunction

  function automatic logic [5:0] gf36_sq(input logic [5:0] a);
    logic [2:0] h2;
    h2 = gf8_sq(a[5:3]);
    return {h2, h2 ^ gf8_sq(a[2:0])};
  endfunction

  // Polynomial basis beta^i mapped onto tower coordinates, beta = z*y
  function automatic logic [5:0] iso(input logic [5:0] a);
    return {a[2] ^ a[4] ^ a[5], a[1] ^ a[4] ^ a[5], a[5],
            a[2] ^ a[5], a[3] ^ a[5], a[0] ^ a[3] ^ a[5]};
  endfunction

  function automatic logic [5:0] inv_iso(input logic [5:0] t);
    return {t[3], t[5] ^ t[2], t[1] ^ t[3], t[2] ^ t[3],
            t[4] ^ t[5] ^ t[2] ^ t[3], t[0] ^ t[1]};
  endfunction

  sms32_38_inv_iter_gf_mul u_mul (.a(mul_a), .b(mul_b), .p(mul_p));

`ifdef SMS_INV_SELFCHECK_EN
  logic [5:0] x_q, x_d, r_q, r_d;
  logic       chk_q, chk_d;
  assign chk_err = chk_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      t_q     <= '0;
      out_y_q <= '0;
`ifdef SMS_INV_SELFCHECK_EN
      x_q     <= '0;
      r_q     <= '0;
      chk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      t_q     <= t_d;
      out_y_q <= out_y_d;
`ifdef SMS_INV_SELFCHECK_EN
      x_q     <= x_d;
      r_q     <= r_d;
      chk_q   <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_SQ;
      S_SQ:    state_d = S_MUL;
`ifdef SMS_INV_SELFCHECK_EN
      S_MUL:   state_d = S_SC1;
      S_SC1:   state_d = S_SC2;
      S_SC2:   state_d = S_OUT;
`else
      S_MUL:   state_d = S_OUT;
`endif
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_OUT);
    mul_a     = t_q;
    mul_b     = w_q;
`ifdef SMS_INV_SELFCHECK_EN
    case (state_q)
      S_SC1: begin
        mul_a = gf36_sq(gf36_sq(gf36_sq(gf36_sq(gf36_sq(r_q)))));
        mul_b = gf36_sq(gf36_sq(r_q));
      end
      S_SC2: begin
        mul_a = t_q;
        mul_b = gf36_sq(r_q);
      end
      default: ;
    endcase
`endif
  end

  always_comb begin
    w_d     = w_q;
    t_d     = t_q;
    out_y_d = out_y_q;
`ifdef SMS_INV_SELFCHECK_EN
    x_d     = x_q;
    r_d     = r_q;
    chk_d   = chk_q;
`endif
    case (state_q)
      S_IDLE: if (in_valid) begin
        w_d = iso(in_x);
`ifdef SMS_INV_SELFCHECK_EN
        x_d = in_x;
`endif
      end
      S_SQ:  t_d = gf36_sq(gf36_sq(w_q));
`ifdef SMS_INV_SELFCHECK_EN
      S_MUL: r_d = mul_p;
      S_SC1: t_d = mul_p;
      S_SC2: begin
        out_y_d = inv_iso(r_q);
        chk_d   = (inv_iso(mul_p) != x_q);
      end
`else
      S_MUL: out_y_d = inv_iso(mul_p);
`endif
      default: ;
    endcase
  end

  assign out_y = out_y_q;
endmodule

// File: tb/tb_sms32_38_inv_iter.sv
// Directed bench for sms32_38_inv_iter; GF(2^6) reference uses x^6+x^4+x^2+x+1.
// Build with SMS_INV_SELFCHECK_EN to cover the forward recheck path.

module tb_sms32_38_inv_iter;
`ifdef SMS_INV_SELFCHECK_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int PERIOD = LAT + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_x = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out_y;
  logic       chk_err;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  sms32_38_inv_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
`ifdef SMS_INV_SELFCHECK_EN
    , .chk_err(chk_err)
`endif
  );
`ifndef SMS_INV_SELFCHECK_EN
  assign chk_err = 1'b0;
`endif

  function automatic logic [5:0] gmul(input logic [5:0] a, input logic [5:0] b);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) if (b[i]) r = r ^ ({6'b0, a} << i);
    for (int i = 11; i >= 6; i--) if (r[i]) r = r ^ (12'h057 << (i - 6));
    return r[5:0];
  endfunction

  function automatic logic [5:0] gpow(input logic [5:0] a, input int n);
    logic [5:0] r;
    r = 6'h01;
    for (int i = 0; i < n; i++) r = gmul(r, a);
    return r;
  endfunction

  // One operand through the block with out_ready=1; reports latency and timeout.
  task automatic run_op(input logic [5:0] x, output logic [5:0] y, output logic chk,
                        output int lat, output bit to);
    int n;
    to = 0;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    in_x = x; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!out_valid) to = 1;
    y = out_y;
    chk = chk_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (out_y !== 6'h00) begin bad++; $display("FAIL rst_out_y: got %h want 00", out_y); end
    total++; if (chk_err !== 1'b0) begin bad++; $display("FAIL rst_chk_err: got %b want 0", chk_err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_rel_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_zero();
    int lat;
    in_x = 6'h00; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL zero_busy_ready: got %b want 0", in_ready); end
      @(posedge clk); #1; lat++;
    end
    total++; if (lat != LAT) begin bad++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT); end
    total++; if (out_y !== 6'h00) begin bad++; $display("FAIL zero_out_y: got %h want 00", out_y); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL zero_out_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_directed();
    logic [5:0] vin [3] = '{6'h01, 6'h02, 6'h04};
    logic [5:0] vexp [3] = '{6'h01, 6'h20, 6'h2C};
    logic [5:0] y;
    logic c;
    int lat;
    bit to;
    for (int i = 0; i < 3; i++) begin
      run_op(vin[i], y, c, lat, to);
      total++; if (to || y !== vexp[i]) begin bad++; $display("FAIL directed_%0d: in %h got %h want %h", i, vin[i], y, vexp[i]); end
    end
  endtask

  task automatic test_exhaustive();
    logic [63:0] seen;
    logic [5:0]  y;
    logic        c;
    int          lat, cnt;
    bit          to;
    seen = '0;
    for (int x = 0; x < 64; x++) begin
      run_op(6'(x), y, c, lat, to);
      total++; if (to || lat != LAT) begin bad++; $display("FAIL exh_latency: in %h got %0d want %0d", x, lat, LAT); end
      total++; if (y !== gpow(6'(x), 5)) begin bad++; $display("FAIL exh_pow5: in %h got %h want %h", x, y, gpow(6'(x), 5)); end
      total++; if (gpow(y, 38) !== 6'(x)) begin bad++; $display("FAIL exh_fwd38: in %h got %h want %h", x, gpow(y, 38), x); end
      total++; if (c !== 1'b0) begin bad++; $display("FAIL exh_chk: in %h got %b want 0", x, c); end
      if (!$isunknown(y)) seen[y] = 1'b1;
    end
    cnt = $countones(seen);
    total++; if (cnt != 64) begin bad++; $display("FAIL exh_distinct: got %0d want 64", cnt); end
  endtask

  task automatic test_backpressure();
    logic [5:0] hold;
    int n;
    in_x = 6'h07; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    hold = out_y;
    total++; if (!out_valid || hold !== gpow(6'h07, 5)) begin bad++; $display("FAIL bp_result: got %h want %h", hold, gpow(6'h07, 5)); end
    in_valid = 1'b1; in_x = 6'h11;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", out_valid); end
      total++; if (out_y !== hold) begin bad++; $display("FAIL bp_stable: got %h want %h", out_y, hold); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready: got %b want 0", in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    total++; if (out_y !== hold) begin bad++; $display("FAIL bp_out_y_kept: got %h want %h", out_y, hold); end
  endtask

  task automatic test_reset_midop();
    logic [5:0] y;
    logic c;
    int lat;
    bit to;
    in_x = 6'h09; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    total++; if (out_y !== 6'h00) begin bad++; $display("FAIL rmid_out_y: got %h want 00", out_y); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_valid: got %b want 0", out_valid); end
    end
    run_op(6'h09, y, c, lat, to);
    total++; if (to || y !== gpow(6'h09, 5)) begin bad++; $display("FAIL rmid_next_op: got %h want %h", y, gpow(6'h09, 5)); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [8] = '{6'h3F, 6'h15, 6'h2A, 6'h01, 6'h33, 6'h0C, 6'h27, 6'h18};
    int acc_idx, res_idx, last_acc, cyc;
    logic rdy_prev;
    acc_idx = 0; res_idx = 0; last_acc = -1; cyc = 0;
    in_x = ops[0]; in_valid = 1'b1; out_ready = 1'b1;
    while ((res_idx < 8) && cyc < 200) begin
      rdy_prev = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (out_valid) begin
        total++; if (res_idx >= 8 || out_y !== gpow(ops[res_idx], 5)) begin
          bad++; $display("FAIL b2b_result_%0d: got %h want %h", res_idx, out_y, gpow(ops[res_idx % 8], 5));
        end
        res_idx++;
      end
      if (rdy_prev && in_valid) begin
        if (last_acc >= 0) begin
          total++; if (cyc - last_acc != PERIOD) begin bad++; $display("FAIL b2b_spacing: got %0d want %0d", cyc - last_acc, PERIOD); end
        end
        last_acc = cyc;
        acc_idx++;
        if (acc_idx < 8) in_x = ops[acc_idx];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    total++; if (res_idx != 8 || acc_idx != 8) begin bad++; $display("FAIL b2b_count: got %0d/%0d want 8/8", acc_idx, res_idx); end
    @(posedge clk); #1;
  endtask

`ifdef SMS_INV_SELFCHECK_EN
  task automatic test_selfcheck();
    logic [5:0] y;
    logic c;
    int lat;
    bit to;
    force dut.mul_p = 6'h15;
    run_op(6'h03, y, c, lat, to);
    release dut.mul_p;
    total++; if (to || c !== 1'b1) begin bad++; $display("FAIL sc_forced_err: got %b want 1", c); end
    run_op(6'h03, y, c, lat, to);
    total++; if (to || c !== 1'b0) begin bad++; $display("FAIL sc_clean: got %b want 0", c); end
    total++; if (y !== gpow(6'h03, 5)) begin bad++; $display("FAIL sc_clean_y: got %h want %h", y, gpow(6'h03, 5)); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero();
    test_directed();
    test_exhaustive();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
`ifdef SMS_INV_SELFCHECK_EN
    test_selfcheck();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sms32_38_inv_iter.md
SMS32_38_INV_ITER -- requirements
Module: sms32_38_inv_iter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  in_x is valid.
REQ-005 in_ready  output  1  block can accept an operand.
REQ-006 in_x  input  6  S-box output value to be inverted.
REQ-007 out_valid  output  1  out_y holds a result.
REQ-008 out_ready  input  1  consumer accepts out_y.
REQ-009 out_y  output  6  inverse S-box result.
REQ-010 chk_err  output  1  self-check mismatch; port exists only when SMS_INV_SELFCHECK_EN is defined (REQ-029).

Function
REQ-011 SHALL compute out_y = in_x^5 in GF(2^6), since 38*5 = 1 mod 63; it is the exact inverse of the SMS32 power-38 S-box.
REQ-012 SHALL use the SMS32 tower-field datapath:
- isomorphism into GF((2^3)^2);
- two squarings to form w^4;
- one shared GF((2^3)^2) multiplier for w^4 * w;
- inverse isomorphism back to GF(2^6).
REQ-013 SHALL instantiate exactly one GF((2^3)^2) multiplier, time-shared; no second multiplier.
REQ-014 FSM states: IDLE, SQ, MUL, OUT; encoding is free.
REQ-015 IDLE: in_ready=1; on in_valid, register w=iso(in_x) and go to SQ.
REQ-016 SQ: register t=w^4 (squaring is linear, no multiplier use); go to MUL.
REQ-017 MUL: register out_y=inv_iso(t*w); go to OUT.
REQ-018 OUT: out_valid=1; on out_ready, go to IDLE; otherwise stay.
REQ-019 in_ready SHALL be 1 only in IDLE; in_x is ignored in every other state.
REQ-020 Latency: accept at edge k gives out_valid=1 from edge k+2.
REQ-021 With out_ready held at 1, sustained throughput SHALL be one result per 4 cycles.
REQ-022 While out_valid=1 and out_ready=0, out_y SHALL hold stable for any number of cycles.
REQ-023 out_valid SHALL fall on the edge where out_valid and out_ready are both 1.
REQ-024 in_x=0 SHALL yield out_y=0; no special-case logic is needed.
REQ-025 Result registers SHALL change only on the MUL->OUT transition.

Reset
REQ-026 rst_n low SHALL force IDLE immediately, regardless of clk.
REQ-027 Reset values: out_valid=0, out_y=0, in_ready=1 (once rst_n is high), internal w/t=0, chk_err=0.
REQ-028 Reset mid-operation (SQ/MUL/OUT) SHALL discard the operation; no out_valid follows.

Configuration
REQ-029 Macro SMS_INV_SELFCHECK_EN:
- Defined: keep in_x in a register; in MUL, recompute forward out^38 with the same shared multiplier via added SC1/SC2 states; register chk_err=1 with out_valid when the result differs from the stored in_x. Latency grows to edge k+4.
- Undefined: chk_err port, check states and stored operand are absent.

Verification
REQ-030 Exhaustive: all 64 in_x, out_ready=1. Required: forward power-38 S-box of out_y == in_x for every input; 64 distinct out_y; chk_err=0.
REQ-031 in_x=0 accepted at edge k. Required: out_valid=1 at edge k+2 with out_y=0x00; in_ready=0 during SQ/MUL/OUT.
REQ-032 Backpressure: out_ready=0 for 5 cycles after out_valid. Required: out_y stable, in_ready=0, new in_valid ignored; out_ready=1 then returns to IDLE next edge.
REQ-033 Reset mid-op: rst_n low during MUL. Required: out_valid=0 and out_y=0 immediately; next accepted operand produces a correct result.
REQ-034 Back-to-back with in_valid held and out_ready=1: 8 operands. Required: accepts exactly every 4th cycle; results in order.
REQ-035 SMS_INV_SELFCHECK_EN defined, with the multiplier output forced wrong via a bench force. Required: chk_err=1 with out_valid.
